// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: NM byte-wide masters onto one RAM/IO bus (master 0 absolute priority, others round-robin with burst cap),
// registered read-data steering and a synchronised, stretched system reset.
module mem_bus_arbiter #(
  parameter int NM          = 2,
  parameter int RAM_AW      = 17,
  parameter int MAX_BURST   = 4,
  parameter int RST_STRETCH = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [NM-1:0]    m_req,
  input  logic [NM*32-1:0] m_a,
  input  logic [NM-1:0]    m_wr,
  input  logic [NM*8-1:0]  m_dout,
  output logic [NM-1:0]    m_gnt,
  output logic [NM-1:0]    m_rvalid,
  output logic [7:0]       m_din,
  output logic             ram_en,
  output logic [RAM_AW-1:0] ram_a,
  output logic             ram_wr,
  output logic [7:0]       ram_d,
  input  logic [7:0]       ram_q,
  output logic             io_en,
  output logic [2:0]       io_sel,
  output logic             io_wr,
  output logic [7:0]       io_d,
  input  logic [7:0]       io_q,
  input  logic             io_full,
  output logic             sys_rst_n_out
);
  localparam int IW = $clog2(NM);
  localparam int CW = $clog2(RST_STRETCH + 1);
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [IW-1:0] ptr_q, ptr_d, own_q, own_d, ridx_q, ridx_d, gnt_idx;
  logic [3:0]    bcnt_q, bcnt_d;
  logic          rv_q, rv_d, rio_q, rio_d, gnt_vld, sel_io, sel_wr;
  logic [31:0]   a_arr [NM];
  logic [7:0]    d_arr [NM];
  logic [31:0]   sel_a;
  logic [7:0]    sel_d;
  logic [NM-1:0] elig;
  logic          unused_a;
  for (genvar i = 0; i < NM; i++) begin : g_split
    assign a_arr[i] = m_a[32*i +: 32];
    assign d_arr[i] = m_dout[8*i +: 8];
    assign elig[i]  = sys_rst_n_out && m_req[i] && !(a_arr[i][RAM_AW:RAM_AW-1] == 2'b11 && m_wr[i] && io_full);
  end
  assign sync_d        = {sync_q[0], 1'b1};
  assign rcnt_d        = !sync_q[1] ? CW'(RST_STRETCH) : (rcnt_q != '0 ? rcnt_q - 1'b1 : '0);
  assign sys_rst_n_out = (rcnt_q == '0);
  // Owner keeps the bus while eligible and under the burst cap; otherwise scan from ptr over masters 1..NM-1.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    ptr_d   = ptr_q;
    own_d   = own_q;
    bcnt_d  = bcnt_q;
    if (elig[0]) begin
      gnt_vld = 1'b1;
    end else if (bcnt_q != 4'd0 && elig[own_q] && bcnt_q < 4'(MAX_BURST)) begin
      gnt_vld = 1'b1;
      gnt_idx = own_q;
      bcnt_d  = bcnt_q + 4'd1;
    end else begin
      for (int k = 0; k < NM - 1; k++)
        if (!gnt_vld && elig[(int'(ptr_q) - 1 + k) % (NM - 1) + 1]) begin
          gnt_vld = 1'b1;
          gnt_idx = IW'((int'(ptr_q) - 1 + k) % (NM - 1) + 1);
        end
      own_d  = gnt_vld ? gnt_idx : own_q;
      bcnt_d = gnt_vld ? 4'd1 : 4'd0;
      ptr_d  = !gnt_vld ? ptr_q : (gnt_idx == IW'(NM - 1) ? IW'(1) : gnt_idx + 1'b1);
    end
  end
  assign sel_a    = a_arr[gnt_idx];
  assign sel_d    = d_arr[gnt_idx];
  assign sel_wr   = m_wr[gnt_idx];
  assign sel_io   = sel_a[RAM_AW:RAM_AW-1] == 2'b11;
  assign unused_a = ^sel_a[31:RAM_AW+1];
  assign m_gnt    = gnt_vld ? NM'(1) << gnt_idx : '0;
  assign ram_en   = gnt_vld && !sel_io;
  assign io_en    = gnt_vld && sel_io;
  assign ram_wr   = ram_en && sel_wr;
  assign io_wr    = io_en && sel_wr;
  assign ram_a    = ram_en ? sel_a[RAM_AW-1:0] : '0;
  assign ram_d    = ram_wr ? sel_d : '0;
  assign io_sel   = io_en ? sel_a[2:0] : '0;
  assign io_d     = io_wr ? sel_d : '0;
  assign rv_d     = gnt_vld && !sel_wr;
  assign ridx_d   = gnt_idx;
  assign rio_d    = sel_io;
  assign m_rvalid = rv_q ? NM'(1) << ridx_q : '0;
  assign m_din    = !rv_q ? 8'h00 : (rio_q ? io_q : ram_q);
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      rcnt_q <= CW'(RST_STRETCH);
      ptr_q  <= IW'(1);
      own_q  <= '0;
      bcnt_q <= '0;
      rv_q   <= 1'b0;
      ridx_q <= '0;
      rio_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      rcnt_q <= rcnt_d;
      ptr_q  <= ptr_d;
      own_q  <= own_d;
      bcnt_q <= bcnt_d;
      rv_q   <= rv_d;
      ridx_q <= ridx_d;
      rio_q  <= rio_d;
    end
  end
endmodule
